// File: rtl/bus_pkg.sv
// Shared bus definitions for the memory responder slice: default widths,
// the responder FSM states and the 8086-style byte-lane decode.
package bus_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Lane codes are {A0, bhe_n}
  localparam logic [1:0] LANE_WORD = 2'b00;
  localparam logic [1:0] LANE_LO   = 2'b01;
  localparam logic [1:0] LANE_HI   = 2'b10;
  localparam logic [1:0] LANE_BAD  = 2'b11;

  // Byte enables {hi, lo} for a lane code; an illegal lane enables nothing
  function automatic logic [1:0] lane_be(input logic [1:0] lane);
    logic [1:0] be;
    case (lane)
      LANE_WORD: be = 2'b11;
      LANE_LO:   be = 2'b01;
      LANE_HI:   be = 2'b10;
      default:   be = 2'b00;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/acknowledge bus between the CPU address path and the memory
// responder. The master raises req and holds it until ack is seen.
interface mem_responder_if;

  logic                        req;
  logic                        we;
  logic [bus_pkg::ADDR_W-1:0]  addr;
  logic                        bhe_n;
  logic [bus_pkg::DATA_W-1:0]  wdata;
  logic [bus_pkg::DATA_W-1:0]  rdata;
  logic                        ack;
  logic                        err;
  logic                        busy;

  modport master (
    output req, we, addr, bhe_n, wdata,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, addr, bhe_n, wdata,
    output rdata, ack, err, busy
  );

endinterface

// File: rtl/mem_responder_mem_array.sv
// Single-port word RAM with per-byte write enables and a registered read.
// The read register only loads when re is asserted, so q keeps the last
// word read across writes and idle cycles.
module mem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] idx,
  input  logic [1:0]       wbe,
  input  logic [15:0]      wdata,
  input  logic             re,
  output logic [15:0]      q
);

  logic [15:0] mem [DEPTH_WORDS];

  // Byte-lane writes and the registered read share the one address port
  always_ff @(posedge clk) begin
    if (wbe[0]) mem[idx][7:0]  <= wdata[7:0];
    if (wbe[1]) mem[idx][15:8] <= wdata[15:8];
    if (re)     q              <= mem[idx];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the 20-bit physical bus. Captures one request,
// counts out the wait states, performs the RAM access in the final WAIT
// cycle and holds ack/err/rdata until the requester drops req.
module mem_responder
  import bus_pkg::*;
#(
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE        = 20'h12000,
  parameter int                WAIT_STATES = 2
) (
  input logic           clk,
  input logic           rst,
  mem_responder_if.slave bus
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic                bhe_n_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                ack_q;
  logic                err_q;
  logic                busy_q;
  logic [1:0]          rmask;

  logic [ADDR_W:0]     offs;
  logic [1:0]          lane;
  logic [1:0]          be;
  logic                in_win;
  logic                bad;
  logic                fire;
  logic [IDX_W-1:0]    idx;
  logic [1:0]          mem_wbe;
  logic                mem_re;
  logic [DATA_W-1:0]   mem_q;

  // Decode the held request: window offset with a borrow bit, lanes, and
  // the single-cycle strobe that performs the RAM access
  always_comb begin
    offs    = {1'b0, addr_q} - {1'b0, BASE};
    lane    = {addr_q[0], bhe_n_q};
    be      = lane_be(lane);
    in_win  = !offs[ADDR_W] && (offs[ADDR_W:1] < ADDR_W'(DEPTH_WORDS));
    bad     = (lane == LANE_BAD) || !in_win;
    idx     = offs[IDX_W:1];
    fire    = (state == WAIT) && (cnt == '0) && !rst;
    mem_wbe = (fire && we_q && !bad) ? be : 2'b00;
    mem_re  = fire && !we_q && !bad;
  end

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_mem (
    .clk   (clk),
    .idx   (idx),
    .wbe   (mem_wbe),
    .wdata (wdata_q),
    .re    (mem_re),
    .q     (mem_q)
  );

  // Handshake FSM; the counter is loaded with WAIT_STATES so that the WAIT
  // cycle where it reads zero is the RAM access cycle and ack rises right after
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
      rmask  <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            addr_q  <= bus.addr;
            we_q    <= bus.we;
            bhe_n_q <= bus.bhe_n;
            wdata_q <= bus.wdata;
            cnt     <= CNT_LOAD;
            busy_q  <= 1'b1;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= ACK;
            ack_q <= 1'b1;
            err_q <= bad;
            if (bad)
              rmask <= 2'b00;
            else if (!we_q)
              rmask <= be;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACK: begin
          if (!bus.req) begin
            state  <= IDLE;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Disabled lanes and error completions read as zero; rmask and the RAM
  // read register are both registers, so rdata is stable outside an access
  always_comb begin
    bus.rdata = {rmask[1] ? mem_q[15:8] : 8'h00,
                 rmask[0] ? mem_q[7:0]  : 8'h00};
  end

  assign bus.ack  = ack_q;
  assign bus.err  = err_q;
  assign bus.busy = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one DUT with two wait states and one with none,
// checked every cycle against a transaction-level model of the RAM window.
module tb_mem_responder;

  localparam int BASE  = 32'h12000;
  localparam int DEPTH = 1024;
  localparam int WS0   = 2;
  localparam int WS1   = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mem_responder_if bus0 ();
  mem_responder_if bus1 ();

  mem_responder #(.DEPTH_WORDS(DEPTH), .BASE(20'h12000), .WAIT_STATES(WS0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  mem_responder #(.DEPTH_WORDS(DEPTH), .BASE(20'h12000), .WAIT_STATES(WS1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model state: expected outputs per DUT and the contents of each window
  logic        exp_ack   [2];
  logic        exp_err   [2];
  logic        exp_busy  [2];
  logic [15:0] exp_rdata [2];
  logic [15:0] exp_known [2];
  logic [15:0] mmem [2][DEPTH];
  logic [1:0]  mkn  [2][DEPTH];

  logic [15:0] last_rdata;
  logic        last_err;
  int          obs_lat;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, want %h at %0t", name, act, want, $time);
    end
  endtask

  function automatic int lat_of(input int d);
    return 1 + ((d == 0) ? WS0 : WS1);
  endfunction

  function automatic logic get_ack(input int d);
    return (d == 0) ? bus0.ack : bus1.ack;
  endfunction
  function automatic logic get_err(input int d);
    return (d == 0) ? bus0.err : bus1.err;
  endfunction
  function automatic logic get_busy(input int d);
    return (d == 0) ? bus0.busy : bus1.busy;
  endfunction
  function automatic logic [15:0] get_rdata(input int d);
    return (d == 0) ? bus0.rdata : bus1.rdata;
  endfunction

  task automatic drive(input int d, input bit r, input bit w, input logic [19:0] a,
                       input bit bn, input logic [15:0] wd);
    if (d == 0) begin
      bus0.req = r; bus0.we = w; bus0.addr = a; bus0.bhe_n = bn; bus0.wdata = wd;
    end else begin
      bus1.req = r; bus1.we = w; bus1.addr = a; bus1.bhe_n = bn; bus1.wdata = wd;
    end
  endtask

  task automatic reset_exp();
    for (int d = 0; d < 2; d++) begin
      exp_ack[d]   = 1'b0;
      exp_err[d]   = 1'b0;
      exp_busy[d]  = 1'b0;
      exp_rdata[d] = 16'h0000;
      exp_known[d] = 16'hFFFF;
    end
  endtask

  // Completion of one access as seen from the bus: error rules, lane
  // selection and the effect on the window contents
  task automatic model_access(input int d, input bit w, input logic [19:0] a,
                              input bit bn, input logic [15:0] wd);
    int ai;
    int idx;
    bit bad;
    logic [1:0] be;
    ai  = int'(a);
    bad = (a[0] && bn) || (ai < BASE) || (ai >= BASE + 2 * DEPTH);
    exp_ack[d] = 1'b1;
    exp_err[d] = bad;
    if (bad) begin
      exp_rdata[d] = 16'h0000;
      exp_known[d] = 16'hFFFF;
      return;
    end
    be  = a[0] ? 2'b10 : (bn ? 2'b01 : 2'b11);
    idx = (ai - BASE) / 2;
    if (w) begin
      if (be[0]) begin mmem[d][idx][7:0]  = wd[7:0];  mkn[d][idx][0] = 1'b1; end
      if (be[1]) begin mmem[d][idx][15:8] = wd[15:8]; mkn[d][idx][1] = 1'b1; end
    end else begin
      exp_rdata[d] = {be[1] ? mmem[d][idx][15:8] : 8'h00,
                      be[0] ? mmem[d][idx][7:0]  : 8'h00};
      exp_known[d] = {(be[1] && !mkn[d][idx][1]) ? 8'h00 : 8'hFF,
                      (be[0] && !mkn[d][idx][0]) ? 8'h00 : 8'hFF};
    end
  endtask

  // One full handshake on DUT d; live inputs are scrambled after capture,
  // and optionally the transfer ends with a reset pulse while ack is high
  task automatic applyStimulus(input int d, input bit w, input logic [19:0] a, input bit bn,
                               input logic [15:0] wd, input int hold, input bit rst_in_ack);
    int lat;
    lat = lat_of(d);
    @(negedge clk);
    drive(d, 1'b1, w, a, bn, wd);
    @(posedge clk); #1;
    exp_busy[d] = 1'b1;
    obs_lat = 0;
    for (int i = 1; i <= lat; i++) begin
      @(posedge clk); #1;
      if (i == lat) model_access(d, w, a, bn, wd);
      @(negedge clk);
      if (get_ack(d) && obs_lat == 0) obs_lat = i;
      if (i == 1) drive(d, 1'b1, ~w, 20'($urandom), ~bn, 16'($urandom));
    end
    last_rdata = get_rdata(d);
    last_err   = get_err(d);
    repeat (hold) @(negedge clk);
    if (rst_in_ack) begin
      rst = 1'b1;
      drive(d, 1'b0, 1'b0, 20'h0, 1'b0, 16'h0);
      @(posedge clk); #1;
      reset_exp();
      @(negedge clk);
      rst = 1'b0;
    end else begin
      drive(d, 1'b0, 1'b0, 20'h0, 1'b0, 16'h0);
      @(posedge clk); #1;
      exp_ack[d]  = 1'b0;
      exp_err[d]  = 1'b0;
      exp_busy[d] = 1'b0;
      @(negedge clk);
    end
  endtask

  // Every-cycle comparison of both DUTs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        checkOutput($sformatf("ack%0d", d),  32'(get_ack(d)),  32'(exp_ack[d]));
        checkOutput($sformatf("err%0d", d),  32'(get_err(d)),  32'(exp_err[d]));
        checkOutput($sformatf("busy%0d", d), 32'(get_busy(d)), 32'(exp_busy[d]));
        if (exp_known[d] != 16'h0000)
          checkOutput($sformatf("rdata%0d", d), 32'(get_rdata(d) & exp_known[d]),
                      32'(exp_rdata[d] & exp_known[d]));
      end
    end
  end

  initial begin
    logic [19:0] ra;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++) begin
        mmem[d][i] = 16'h0000;
        mkn[d][i]  = 2'b00;
      end
    reset_exp();
    drive(0, 1'b0, 1'b0, 20'h0, 1'b0, 16'h0);
    drive(1, 1'b1, 1'b0, 20'h12000, 1'b0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 20'h0, 1'b0, 16'h0);
    rst = 1'b0;
    checkOutput("reset_ack", 32'(bus0.ack), 32'h0);
    checkOutput("reset_busy", 32'(bus0.busy), 32'h0);
    checkOutput("reset_rdata", 32'(bus0.rdata), 32'h0);

    // Word write and read-back, with latency pinned
    applyStimulus(0, 1'b1, 20'h12350, 1'b0, 16'hBEEF, 0, 1'b0);
    checkOutput("wr_lat", 32'(obs_lat), 32'd3);
    checkOutput("wr_err", 32'(last_err), 32'h0);
    applyStimulus(0, 1'b0, 20'h12350, 1'b0, 16'h0, 0, 1'b0);
    checkOutput("rd_lat", 32'(obs_lat), 32'd3);
    checkOutput("rd_beef", 32'(last_rdata), 32'hBEEF);

    // Byte lanes
    applyStimulus(0, 1'b1, 20'h12351, 1'b0, 16'hAA00, 0, 1'b0);
    applyStimulus(0, 1'b0, 20'h12350, 1'b0, 16'h0, 0, 1'b0);
    checkOutput("rd_aaef", 32'(last_rdata), 32'hAAEF);
    applyStimulus(0, 1'b0, 20'h12350, 1'b1, 16'h0, 0, 1'b0);
    checkOutput("rd_lo", 32'(last_rdata), 32'h00EF);
    applyStimulus(0, 1'b0, 20'h12351, 1'b0, 16'h0, 0, 1'b0);
    checkOutput("rd_hi", 32'(last_rdata), 32'hAA00);

    // Window edges and illegal lane
    applyStimulus(0, 1'b1, 20'h12800, 1'b0, 16'h1111, 0, 1'b0);
    checkOutput("past_err", 32'(last_err), 32'h1);
    applyStimulus(0, 1'b0, 20'h12800, 1'b0, 16'h0, 0, 1'b0);
    checkOutput("past_rdata", 32'(last_rdata), 32'h0);
    applyStimulus(0, 1'b0, 20'h11FFE, 1'b0, 16'h0, 0, 1'b0);
    checkOutput("below_err", 32'(last_err), 32'h1);
    applyStimulus(0, 1'b1, 20'h127FE, 1'b0, 16'hC0DE, 0, 1'b0);
    applyStimulus(0, 1'b0, 20'h127FE, 1'b0, 16'h0, 0, 1'b0);
    checkOutput("top_word", 32'(last_rdata), 32'hC0DE);
    applyStimulus(0, 1'b1, 20'h12351, 1'b1, 16'h5A5A, 0, 1'b0);
    checkOutput("bad_lane_err", 32'(last_err), 32'h1);
    applyStimulus(0, 1'b0, 20'h12350, 1'b0, 16'h0, 10, 1'b0);
    checkOutput("unchanged", 32'(last_rdata), 32'hAAEF);

    // Write, then a second write aborted by reset during WAIT
    applyStimulus(0, 1'b1, 20'h12000, 1'b0, 16'h1234, 0, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 20'h12000, 1'b0, 16'h5555);
    @(posedge clk); #1;
    exp_busy[0] = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 20'h0, 1'b0, 16'h0);
    @(posedge clk); #1;
    reset_exp();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 1'b0, 20'h12000, 1'b0, 16'h0, 0, 1'b0);
    checkOutput("abort_keeps", 32'(last_rdata), 32'h1234);

    // Reset while ack is high: the write has already landed
    applyStimulus(0, 1'b1, 20'h12002, 1'b0, 16'h7777, 2, 1'b1);
    applyStimulus(0, 1'b0, 20'h12002, 1'b0, 16'h0, 0, 1'b0);
    checkOutput("rst_in_ack", 32'(last_rdata), 32'h7777);

    // Zero wait states
    applyStimulus(1, 1'b1, 20'h12000, 1'b0, 16'h1234, 0, 1'b0);
    checkOutput("ws0_wr_lat", 32'(obs_lat), 32'd1);
    applyStimulus(1, 1'b0, 20'h12000, 1'b0, 16'h0, 3, 1'b0);
    checkOutput("ws0_rd_lat", 32'(obs_lat), 32'd1);
    checkOutput("ws0_rdata", 32'(last_rdata), 32'h1234);

    // Randomized traffic on both DUTs
    for (int n = 0; n < 120; n++) begin
      int d;
      int cat;
      d   = int'($urandom_range(0, 1));
      cat = int'($urandom_range(0, 9));
      case (cat)
        0:       ra = 20'(BASE - 1 - int'($urandom_range(0, 7)));
        1:       ra = 20'(BASE + 2 * DEPTH + int'($urandom_range(0, 7)));
        2:       ra = 20'(BASE + 2 * DEPTH - 1 - int'($urandom_range(0, 3)));
        default: ra = 20'(BASE + int'($urandom_range(0, 63)));
      endcase
      applyStimulus(d, 1'($urandom), ra, 1'($urandom), 16'($urandom),
                    int'($urandom_range(0, 2)), 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
